dp_stream_arbiter: RTL and testbench

Two-requester arbiter that shares one 32-bit valid-qualified streaming datapath (ports clk, rst, validi, data_in, valido, data_out) between two independent producers. It accepts words from each requester over a valid/ready handshake and issues at most one word per cycle into the datapath. It tags each issued word with its owner in an in-order tag FIFO and routes every datapath result back to the requester that issued it. It sits directly in front of and behind the shared datapath instance.

---
 rtl/dp_stream_arbiter.sv | 104 ++++++++++
 tb/tb_dp_stream_arbiter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dp_stream_arbiter.sv
// Two-requester arbiter in front of a shared in-order streaming datapath; results are routed back by owner tag.
// Optional DP_ARB_FIXED_PRIO_EN: requester 0 always wins contention (default build is round-robin).
module dp_stream_arbiter #(
  parameter int unsigned TAG_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic [31:0] req0_data,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [31:0] req1_data,
  output logic        req1_ready,
  output logic        dp_validi,
  output logic [31:0] dp_data_in,
  input  logic        dp_valido,
  input  logic [31:0] dp_data_out,
  output logic        rsp0_valid,
  output logic        rsp1_valid,
  output logic [31:0] rsp_data,
  output logic        err
);

  localparam int unsigned PW = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
  localparam int unsigned CW = PW + 1;

  logic                 last_grant;
  logic [TAG_DEPTH-1:0] tag_mem;
  logic [PW-1:0]        wr_ptr;
  logic [PW-1:0]        rd_ptr;
  logic [CW-1:0]        count;

  logic grant0;
  logic grant1;
  logic tag_full;
  logic issue;
  logic winner;
  logic pop;
  logic head;

  // Grant: a lone requester wins; on contention the one not served last wins.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (req0_valid && !req1_valid) begin
      grant0 = 1'b1;
    end else if (!req0_valid && req1_valid) begin
      grant1 = 1'b1;
    end else if (req0_valid && req1_valid) begin
`ifdef DP_ARB_FIXED_PRIO_EN
      grant0 = 1'b1;
`else
      grant0 = last_grant;
      grant1 = ~last_grant;
`endif
    end
  end

  // Full blocks issue even when a pop lands in the same cycle.
  always_comb begin
    tag_full   = (count == CW'(TAG_DEPTH));
    req0_ready = grant0 & ~tag_full & ~rst;
    req1_ready = grant1 & ~tag_full & ~rst;
    issue      = (req0_valid & req0_ready) | (req1_valid & req1_ready);
    winner     = req1_valid & req1_ready;
    pop        = dp_valido & (count != '0);
    head       = tag_mem[rd_ptr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= 1'b1;
      tag_mem    <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      dp_validi  <= 1'b0;
      dp_data_in <= '0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp_data   <= '0;
      err        <= 1'b0;
    end else begin
      dp_validi <= issue;
      if (issue) begin
        dp_data_in      <= winner ? req1_data : req0_data;
        last_grant      <= winner;
        tag_mem[wr_ptr] <= winner;
        wr_ptr          <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr   <= rd_ptr + PW'(1);
        rsp_data <= dp_data_out;
      end
      rsp0_valid <= pop & ~head;
      rsp1_valid <= pop & head;
      if (dp_valido && (count == '0)) begin
        err <= 1'b1;
      end
      count <= count + CW'(issue) - CW'(pop);
    end
  end

endmodule

// File: tb/tb_dp_stream_arbiter.sv
// Bench for dp_stream_arbiter: stub in-order datapath plus a queue-based reference model checked every cycle.
module tb_dp_stream_arbiter;

  localparam int TAG_DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 1'b0;
  logic [31:0] req0_data = '0;
  logic        req0_ready;
  logic        req1_valid = 1'b0;
  logic [31:0] req1_data = '0;
  logic        req1_ready;
  logic        dp_validi;
  logic [31:0] dp_data_in;
  logic        dp_valido = 1'b0;
  logic [31:0] dp_data_out = '0;
  logic        rsp0_valid;
  logic        rsp1_valid;
  logic [31:0] rsp_data;
  logic        err;

  dp_stream_arbiter #(.TAG_DEPTH(TAG_DEPTH)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .dp_validi(dp_validi), .dp_data_in(dp_data_in),
    .dp_valido(dp_valido), .dp_data_out(dp_data_out),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid), .rsp_data(rsp_data),
    .err(err)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // requester and stub datapath state
  logic        v0, v1;
  logic [31:0] d0, d1;
  logic [31:0] src0[$], src1[$];
  int          p_offer = 100;
  int          lat = 2;
  bit          force_valido = 0;
  logic [31:0] dpq[$];
  int          dpq_due[$];
  int          cyc = 0;

  // reference model
  bit          m_last;
  bit          mtags[$];
  logic        e_validi, e_rsp0, e_rsp1, e_err;
  logic [31:0] e_data_in, e_rsp_data;
  logic [31:0] exp0[$], exp1[$];

  // observation logs
  logic [31:0] ilog[$], r0log[$], r1log[$];
  int          icyc[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    else passed++;
  endtask

  function automatic int model_grant(input bit a, input bit b);
    if (a && !b) return 0;
    if (!a && b) return 1;
    if (a && b) begin
`ifdef DP_ARB_FIXED_PRIO_EN
      return 0;
`else
      return m_last ? 0 : 1;
`endif
    end
    return -1;
  endfunction

  task automatic clear_state();
    m_last = 1; mtags.delete();
    e_validi = 0; e_rsp0 = 0; e_rsp1 = 0; e_err = 0; e_data_in = '0; e_rsp_data = '0;
    exp0.delete(); exp1.delete();
    v0 = 0; v1 = 0; d0 = '0; d1 = '0; src0.delete(); src1.delete();
    dpq.delete(); dpq_due.delete(); force_valido = 0;
    ilog.delete(); icyc.delete(); r0log.delete(); r1log.delete();
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst = 1; req0_valid = 1; req1_valid = 1; dp_valido = 0;
    #1;
    chk("rst_dp_validi", 32'(dp_validi), 0);
    chk("rst_dp_data_in", dp_data_in, 0);
    chk("rst_rsp0", 32'(rsp0_valid), 0);
    chk("rst_rsp1", 32'(rsp1_valid), 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_ready0", 32'(req0_ready), 0);
    chk("rst_ready1", 32'(req1_ready), 0);
    clear_state();
    repeat (2) @(negedge clk);
    rst = 0; req0_valid = 0; req1_valid = 0;
  endtask

  task automatic cycle();
    int  g;
    bit  full, iss, pop;
    logic [31:0] w;
    @(negedge clk);
    cyc++;
    dp_valido = 0;
    dp_data_out = $urandom;
    if (force_valido) begin
      dp_valido = 1; force_valido = 0;
    end else if (dpq.size() > 0 && dpq_due[0] == cyc) begin
      dp_valido = 1; dp_data_out = dpq.pop_front(); void'(dpq_due.pop_front());
    end
    if (!v0 && src0.size() > 0 && $urandom_range(99) < p_offer) begin v0 = 1; d0 = src0.pop_front(); end
    if (!v1 && src1.size() > 0 && $urandom_range(99) < p_offer) begin v1 = 1; d1 = src1.pop_front(); end
    req0_valid = v0; req0_data = d0; req1_valid = v1; req1_data = d1;
    #1;
    chk("dp_validi", 32'(dp_validi), 32'(e_validi));
    if (e_validi) chk("dp_data_in", dp_data_in, e_data_in);
    chk("rsp0_valid", 32'(rsp0_valid), 32'(e_rsp0));
    chk("rsp1_valid", 32'(rsp1_valid), 32'(e_rsp1));
    chk("rsp_data", rsp_data, e_rsp_data);
    chk("err", 32'(err), 32'(e_err));
    if (dp_validi) begin
      dpq.push_back(dp_data_in); dpq_due.push_back(cyc + lat);
      ilog.push_back(dp_data_in); icyc.push_back(cyc);
    end
    if (rsp0_valid) begin
      r0log.push_back(rsp_data);
      if (exp0.size() == 0) chk("rsp0_unexpected", 32'(rsp0_valid), 0);
      else chk("rsp0_order", rsp_data, exp0.pop_front());
    end
    if (rsp1_valid) begin
      r1log.push_back(rsp_data);
      if (exp1.size() == 0) chk("rsp1_unexpected", 32'(rsp1_valid), 0);
      else chk("rsp1_order", rsp_data, exp1.pop_front());
    end
    // model: ready from grant and credit, then next-cycle outputs
    full = (mtags.size() == TAG_DEPTH);
    g = model_grant(v0, v1);
    chk("req0_ready", 32'(req0_ready), 32'(g == 0 && !full));
    chk("req1_ready", 32'(req1_ready), 32'(g == 1 && !full));
    iss = (g >= 0) && !full;
    pop = dp_valido && (mtags.size() > 0);
    e_rsp0 = pop && (mtags[0] == 1'b0);
    e_rsp1 = pop && (mtags[0] == 1'b1);
    if (pop) begin e_rsp_data = dp_data_out; void'(mtags.pop_front()); end
    if (dp_valido && !pop) e_err = 1;
    e_validi = iss;
    if (iss) begin
      w = (g == 0) ? d0 : d1;
      e_data_in = w;
      m_last = (g == 1);
      mtags.push_back(g == 1);
      if (g == 0) exp0.push_back(w); else exp1.push_back(w);
    end
    if (v0 && req0_ready) v0 = 0;
    if (v1 && req1_ready) v1 = 0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    logic [31:0] want[4];
    clear_state();
    reset_dut();

    // req0 only, 2-cycle datapath
    lat = 2; p_offer = 100;
    for (int i = 1; i <= 4; i++) src0.push_back(32'(i));
    run(12);
    chk("p1_issue_count", 32'(ilog.size()), 4);
    for (int i = 0; i < 4 && i < ilog.size(); i++) begin
      chk("p1_dp_data_in", ilog[i], 32'(i + 1));
      chk("p1_consecutive", 32'(icyc[i] - icyc[0]), 32'(i));
    end
    chk("p1_rsp0_count", 32'(r0log.size()), 4);
    for (int i = 0; i < 4 && i < r0log.size(); i++) chk("p1_rsp0_data", r0log[i], 32'(i + 1));
    chk("p1_rsp1_count", 32'(r1log.size()), 0);

    // continuous contention
    reset_dut();
    lat = 2;
    for (int i = 0; i < 4; i++) begin src0.push_back(32'h10 + 32'(i)); src1.push_back(32'h20 + 32'(i)); end
    run(16);
`ifdef DP_ARB_FIXED_PRIO_EN
    want = '{32'h10, 32'h11, 32'h12, 32'h13};
`else
    want = '{32'h10, 32'h20, 32'h11, 32'h21};
`endif
    chk("p2_issue_count", 32'(ilog.size()), 8);
    for (int i = 0; i < 4 && i < ilog.size(); i++) chk("p2_order", ilog[i], want[i]);
    chk("p2_rsp0_count", 32'(r0log.size()), 4);
    chk("p2_rsp1_count", 32'(r1log.size()), 4);

    // latency 8 saturates the tag FIFO
    reset_dut();
    lat = 8;
    for (int i = 0; i < 6; i++) src0.push_back(32'h100 + 32'(i));
    run(30);
    chk("p3_issue_count", 32'(ilog.size()), 6);
    if (ilog.size() >= 5) begin
      chk("p3_first_four", 32'(icyc[3] - icyc[0]), 3);
      chk("p3_resume", 32'(icyc[4] - icyc[0]), 10);
    end

    // result with nothing in flight
    reset_dut();
    run(3);
    force_valido = 1;
    run(4);
    chk("p4_err_sticky", 32'(err), 1);
    chk("p4_no_rsp", 32'(r0log.size() + r1log.size()), 0);
    reset_dut();
    chk("p4_err_cleared", 32'(err), 0);

    // reset with 3 words in flight, then a fresh req1 word
    lat = 8;
    for (int i = 0; i < 3; i++) src0.push_back(32'h300 + 32'(i));
    run(5);
    chk("p5_inflight", 32'(mtags.size()), 3);
    reset_dut();
    src1.push_back(32'hAB);
    run(12);
    chk("p5_rsp1_count", 32'(r1log.size()), 1);
    if (r1log.size() > 0) chk("p5_rsp1_data", r1log[0], 32'hAB);
    chk("p5_rsp0_count", 32'(r0log.size()), 0);

    // randomized traffic across several latencies
    for (int b = 0; b < 5; b++) begin
      lat = (b == 4) ? 8 : 1 + 2 * b;
      p_offer = 40 + 15 * b;
      for (int i = 0; i < 40; i++) begin src0.push_back($urandom); src1.push_back($urandom); end
      run(320);
      chk("rand_drain0", 32'(exp0.size()), 0);
      chk("rand_drain1", 32'(exp1.size()), 0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
